// File: rtl/spi_slave_pkg.sv
// Shared types for the SPI slave front end: FSM states, frame commands, error codes.
package spi_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHK_CMD  = 3'd1,
        ST_RX       = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_RD_SHIFT = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_ABORT   = 2'b01,
        ERR_NO_ADDR = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_e;

    // Bits needed for a counter that must hold every value 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spi_bit_shifter.sv
// W-bit shift register with parallel load; LSB_FIRST selects the shift direction.
module spi_bit_shifter #(
    parameter int unsigned W         = 8,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         shift,
    input  logic         shift_in,
    output logic [W-1:0] q
);

    // MSB-first enters at bit 0 and leaves from bit W-1; LSB-first is the mirror.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            if (LSB_FIRST) q <= {shift_in, q[W-1:1]};
            else           q <= {q[W-2:0], shift_in};
        end
    end

endmodule

// File: rtl/spi_slave_param_if.sv
// SPI slave front end: deserialises {cmd, payload} frames from MOSI and serialises
// read data onto MISO, with abort / missing-address / timeout error reporting.
module spi_slave_param_if
    import spi_slave_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter bit          LSB_FIRST  = 1'b0,
    parameter int unsigned TX_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic              busy
);

    localparam int unsigned F     = DATA_W + 2;
    localparam int unsigned CNT_W = cnt_width(F);
    localparam int unsigned TMO_W = cnt_width(TX_TIMEOUT);
    localparam logic [DATA_W-1:0] TX_FIRST =
        LSB_FIRST ? DATA_W'(1) : {1'b1, {(DATA_W-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [1:0]        cmd_q, cmd_d;
    logic              seen_q, seen_d;
    logic [DATA_W+1:0] rx_data_d;
    logic              rx_valid_d;
    logic              err_valid_d;
    logic [1:0]        err_code_d;

    logic              rx_shift;
    logic              tx_load;
    logic              tx_shift;
    logic [DATA_W-1:0] tx_load_data;
    logic [DATA_W-1:0] rx_q;
    logic [DATA_W-1:0] tx_q;

    spi_bit_shifter #(.W(DATA_W), .LSB_FIRST(LSB_FIRST)) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (1'b0),
        .load_data ('0),
        .shift     (rx_shift),
        .shift_in  (mosi),
        .q         (rx_q)
    );

    spi_bit_shifter #(.W(DATA_W), .LSB_FIRST(LSB_FIRST)) u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (tx_load),
        .load_data (tx_load_data),
        .shift     (tx_shift),
        .shift_in  (1'b0),
        .q         (tx_q)
    );

    // The TX register drains to zero, so its outgoing bit is 0 whenever no read is in flight.
    assign miso = |(tx_q & TX_FIRST);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            tmo_q     <= '0;
            cmd_q     <= '0;
            seen_q    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
            busy      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            cmd_q     <= cmd_d;
            seen_q    <= seen_d;
            rx_data   <= rx_data_d;
            rx_valid  <= rx_valid_d;
            err_valid <= err_valid_d;
            err_code  <= err_code_d;
            busy      <= (state_d != ST_IDLE);
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tmo_d        = tmo_q;
        cmd_d        = cmd_q;
        seen_d       = seen_q;
        rx_data_d    = rx_data;
        rx_valid_d   = 1'b0;
        err_valid_d  = 1'b0;
        err_code_d   = err_code;
        rx_shift     = 1'b0;
        tx_load      = 1'b0;
        tx_shift     = 1'b0;
        tx_load_data = tx_data;

        // Deselect wins over everything else in a non-idle state.
        if (state_q != ST_IDLE && ss_n) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            tmo_d        = '0;
            tx_load      = 1'b1;
            tx_load_data = '0;
            if (state_q != ST_DONE) begin
                err_valid_d = 1'b1;
                err_code_d  = ERR_ABORT;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    tmo_d = '0;
                    if (!ss_n) state_d = ST_CHK_CMD;
                end
                ST_CHK_CMD: begin
                    cmd_d[1] = mosi;
                    cnt_d    = CNT_W'(1);
                    state_d  = ST_RX;
                end
                ST_RX: begin
                    if (cnt_q == CNT_W'(F)) begin
                        cnt_d = '0;
                        case (cmd_e'(cmd_q))
                            CMD_RD_DATA: begin
                                if (seen_q) begin
                                    rx_valid_d = 1'b1;
                                    rx_data_d  = {cmd_q, rx_q};
                                    tmo_d      = '0;
                                    state_d    = ST_RD_WAIT;
                                end else begin
                                    err_valid_d = 1'b1;
                                    err_code_d  = ERR_NO_ADDR;
                                    state_d     = ST_DONE;
                                end
                            end
                            CMD_RD_ADDR: begin
                                rx_valid_d = 1'b1;
                                rx_data_d  = {cmd_q, rx_q};
                                seen_d     = 1'b1;
                                state_d    = ST_DONE;
                            end
                            default: begin
                                rx_valid_d = 1'b1;
                                rx_data_d  = {cmd_q, rx_q};
                                state_d    = ST_DONE;
                            end
                        endcase
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) cmd_d[0] = mosi;
                        else                    rx_shift = 1'b1;
                    end
                end
                ST_RD_WAIT: begin
                    if (tx_valid) begin
                        tx_load = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_RD_SHIFT;
                    end else if (tmo_q == TMO_W'(TX_TIMEOUT - 1)) begin
                        tmo_d       = '0;
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_TIMEOUT;
                        state_d     = ST_DONE;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                ST_RD_SHIFT: begin
                    tx_shift = 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_d   = '0;
                        seen_d  = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_param_if.sv
// Directed bench for spi_slave_param_if: one MSB-first and one LSB-first instance.
module tb_spi_slave_param_if;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ss_n_m, mosi_m, tx_valid_m;
    logic [7:0] tx_data_m;
    logic       ss_n_l, mosi_l, tx_valid_l;
    logic [7:0] tx_data_l;

    logic       miso_m, rx_valid_m, err_valid_m, busy_m;
    logic [9:0] rx_data_m;
    logic [1:0] err_code_m;
    logic       miso_l, rx_valid_l, err_valid_l, busy_l;
    logic [9:0] rx_data_l;
    logic [1:0] err_code_l;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] b;

    always #5 clk = ~clk;

    spi_slave_param_if #(.DATA_W(8), .LSB_FIRST(1'b0), .TX_TIMEOUT(15)) dut_m (
        .clk(clk), .rst_n(rst_n), .ss_n(ss_n_m), .mosi(mosi_m), .miso(miso_m),
        .rx_data(rx_data_m), .rx_valid(rx_valid_m), .tx_data(tx_data_m),
        .tx_valid(tx_valid_m), .err_valid(err_valid_m), .err_code(err_code_m),
        .busy(busy_m)
    );

    spi_slave_param_if #(.DATA_W(8), .LSB_FIRST(1'b1), .TX_TIMEOUT(15)) dut_l (
        .clk(clk), .rst_n(rst_n), .ss_n(ss_n_l), .mosi(mosi_l), .miso(miso_l),
        .rx_data(rx_data_l), .rx_valid(rx_valid_l), .tx_data(tx_data_l),
        .tx_valid(tx_valid_l), .err_valid(err_valid_l), .err_code(err_code_l),
        .busy(busy_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic drive(input bit lsb, input logic s, input logic m);
        if (lsb) begin ss_n_l = s; mosi_l = m; end
        else     begin ss_n_m = s; mosi_m = m; end
    endtask

    // Select, then clock out nbits of w starting at w[9]; ends with the last bit sampled.
    task automatic send(input bit lsb, input logic [9:0] w, input int nbits);
        drive(lsb, 1'b0, 1'b0);
        tick;
        for (int i = 0; i < nbits; i++) begin
            drive(lsb, 1'b0, w[9-i]);
            tick;
        end
        drive(lsb, 1'b0, 1'b0);
    endtask

    task automatic release_ss(input bit lsb);
        drive(lsb, 1'b1, 1'b0);
        tick;
    endtask

    task automatic set_tx(input bit lsb, input logic v, input logic [7:0] d);
        if (lsb) begin tx_valid_l = v; tx_data_l = d; end
        else     begin tx_valid_m = v; tx_data_m = d; end
    endtask

    // Collect 8 MISO bits back into numeric order.
    task automatic read_byte(input bit lsb, output logic [7:0] r);
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (lsb) r[i]   = miso_l;
            else     r[7-i] = miso_m;
            if (i < 7) tick;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        set_tx(1'b0, 1'b0, 8'h00);
        set_tx(1'b1, 1'b0, 8'h00);
        repeat (3) tick;
        check("rst_rx_data",  32'(rx_data_m),   0);
        check("rst_rx_valid", 32'(rx_valid_m),  0);
        check("rst_err_valid",32'(err_valid_m), 0);
        check("rst_err_code", 32'(err_code_m),  0);
        check("rst_busy",     32'(busy_m),      0);
        check("rst_miso",     32'(miso_m),      0);
        check("rst_busy_l",   32'(busy_l),      0);
        rst_n = 1'b1;
        tick;

        // write address, MSB first
        send(1'b0, 10'b00_1010_0101, 10);
        check("wa_early_rxv", 32'(rx_valid_m), 0);
        check("wa_busy",      32'(busy_m),     1);
        tick;
        check("wa_rxv",  32'(rx_valid_m), 1);
        check("wa_data", 32'(rx_data_m),  32'h0A5);
        tick;
        check("wa_pulse", 32'(rx_valid_m), 0);
        check("wa_miso",  32'(miso_m),     0);
        release_ss(1'b0);
        check("wa_idle",  32'(busy_m),      0);
        check("wa_noerr", 32'(err_valid_m), 0);

        // read address then read data
        send(1'b0, 10'b10_0000_0011, 10);
        tick;
        check("ra_rxv",  32'(rx_valid_m), 1);
        check("ra_data", 32'(rx_data_m),  32'h203);
        release_ss(1'b0);
        send(1'b0, 10'b11_0000_0000, 10);
        tick;
        check("rd_rxv",  32'(rx_valid_m), 1);
        check("rd_data", 32'(rx_data_m),  32'h300);
        tick;
        tick;
        check("rd_wait_miso", 32'(miso_m), 0);
        set_tx(1'b0, 1'b1, 8'hC3);
        tick;
        set_tx(1'b0, 1'b0, 8'h00);
        read_byte(1'b0, b);
        check("rd_miso", 32'(b), 32'hC3);
        tick;
        check("rd_miso_end", 32'(miso_m), 0);
        check("rd_done_busy", 32'(busy_m), 1);
        check("rd_no_err", 32'(err_valid_m), 0);
        release_ss(1'b0);

        // address consumed by the read: cmd 11 now fails
        send(1'b0, 10'b11_0000_0000, 10);
        tick;
        check("na_rxv",  32'(rx_valid_m),  0);
        check("na_err",  32'(err_valid_m), 1);
        check("na_code", 32'(err_code_m),  2);
        tick;
        check("na_pulse", 32'(err_valid_m), 0);
        check("na_hold",  32'(err_code_m),  2);
        release_ss(1'b0);

        // reset mid-frame is silent and forgets the read address
        send(1'b0, 10'b10_0000_0001, 10);
        tick;
        check("rs_ra_rxv", 32'(rx_valid_m), 1);
        release_ss(1'b0);
        send(1'b0, 10'b01_1111_1111, 4);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0);
        check("rs_err",  32'(err_valid_m), 0);
        check("rs_busy", 32'(busy_m),      0);
        check("rs_code", 32'(err_code_m),  0);
        tick;
        check("rs_err2", 32'(err_valid_m), 0);
        send(1'b0, 10'b11_0000_0000, 10);
        tick;
        check("rs_na_rxv",  32'(rx_valid_m),  0);
        check("rs_na_err",  32'(err_valid_m), 1);
        check("rs_na_code", 32'(err_code_m),  2);
        release_ss(1'b0);

        // abort after 5 bits, then a clean frame
        send(1'b0, 10'b01_1111_0000, 5);
        drive(1'b0, 1'b1, 1'b0);
        tick;
        check("ab_err",  32'(err_valid_m), 1);
        check("ab_code", 32'(err_code_m),  1);
        check("ab_rxv",  32'(rx_valid_m),  0);
        check("ab_busy", 32'(busy_m),      0);
        tick;
        check("ab_pulse", 32'(err_valid_m), 0);
        send(1'b0, 10'b01_0011_1100, 10);
        tick;
        check("ab2_rxv",  32'(rx_valid_m), 1);
        check("ab2_data", 32'(rx_data_m),  32'h13C);
        release_ss(1'b0);

        // deselect in the completion cycle beats the rx_valid
        send(1'b0, 10'b00_0000_0001, 10);
        drive(1'b0, 1'b1, 1'b0);
        tick;
        check("ac_rxv",  32'(rx_valid_m),  0);
        check("ac_err",  32'(err_valid_m), 1);
        check("ac_code", 32'(err_code_m),  1);
        tick;

        // tx timeout keeps the read address
        send(1'b0, 10'b10_0000_0001, 10);
        tick;
        release_ss(1'b0);
        send(1'b0, 10'b11_0000_0000, 10);
        tick;
        check("to_rxv", 32'(rx_valid_m), 1);
        repeat (14) tick;
        check("to_early", 32'(err_valid_m), 0);
        check("to_busy",  32'(busy_m),      1);
        tick;
        check("to_err",  32'(err_valid_m), 1);
        check("to_code", 32'(err_code_m),  3);
        release_ss(1'b0);
        check("to_noerr", 32'(err_valid_m), 0);
        send(1'b0, 10'b11_0000_0000, 10);
        tick;
        check("to2_rxv", 32'(rx_valid_m), 1);
        set_tx(1'b0, 1'b1, 8'h5A);
        tick;
        set_tx(1'b0, 1'b0, 8'h00);
        read_byte(1'b0, b);
        check("to2_miso", 32'(b), 32'h5A);
        tick;
        release_ss(1'b0);

        // LSB-first instance
        send(1'b1, 10'b01_1010_0101, 10);
        tick;
        check("ls_rxv",  32'(rx_valid_l), 1);
        check("ls_data", 32'(rx_data_l),  32'h1A5);
        release_ss(1'b1);
        send(1'b1, 10'b10_0000_0000, 10);
        tick;
        release_ss(1'b1);
        send(1'b1, 10'b11_0000_0000, 10);
        tick;
        check("ls_rd_rxv", 32'(rx_valid_l), 1);
        set_tx(1'b1, 1'b1, 8'h01);
        tick;
        set_tx(1'b1, 1'b0, 8'h00);
        check("ls_first", 32'(miso_l), 1);
        read_byte(1'b1, b);
        check("ls_miso", 32'(b), 32'h01);
        tick;
        check("ls_err", 32'(err_valid_l), 0);
        check("ls_code", 32'(err_code_l), 0);
        check("ls_busy", 32'(busy_l), 1);
        release_ss(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_param_if.md
Name: spi_slave_param_if

Overview:
Parametrised next-generation SPI slave front end. It deserialises command frames (2-bit command + DATA_W-bit payload) from MOSI into a parallel word for the RAM/register side. It serialises read data returned by that side onto MISO. Additions over the first generation:
- Configurable data width and bit order.
- Single-cycle rx_valid strobe.
- Bounded wait on tx_valid.
- Explicit error reporting for aborted or illegal frames.

The bit clock is clk; ss_n, mosi and miso are all sampled and driven on posedge clk.

Parameters:
DATA_W, 8, payload width in bits (>=2); frame length F = DATA_W+2.
LSB_FIRST, 0, 1 = payload bits travel LSB first on MOSI and MISO; command bits are always MSB first.
TX_TIMEOUT, 15, max cycles spent in RD_WAIT for tx_valid before an error is raised.

Ports:
clk  in  1  bit/system clock.
rst_n  in  1  synchronous, active-low reset.
ss_n  in  1  slave select, active low.
mosi  in  1  serial data from master.
miso  out  1  serial data to master, registered.
rx_data  out  DATA_W+2  {cmd[1:0], payload}; payload is always in numeric order regardless of LSB_FIRST.
rx_valid  out  1  one-cycle strobe; rx_data is valid in that cycle.
tx_data  in  DATA_W  read data from the RAM side.
tx_valid  in  1  tx_data is valid; sampled only in RD_WAIT.
err_valid  out  1  one-cycle error strobe.
err_code  out  2  01 abort, 10 read-data without prior read-address, 11 tx timeout; holds its last value.
busy  out  1  high when state != IDLE.

Behaviour:
- Reset (rst_n=0 at posedge clk) sets: state IDLE, miso 0, rx_data 0, rx_valid 0, err_valid 0, err_code 00, rd_addr_seen 0, bit counter 0, timeout counter 0.
- Reset mid-frame discards the frame silently: no err_valid.
- States: IDLE, CHK_CMD, RX, RD_WAIT, RD_SHIFT, DONE.
- IDLE:
  - ss_n=0 -> CHK_CMD.
  - miso=0, counters 0.
- CHK_CMD:
  - mosi is frame bit F-1 (cmd[1]); store it, count=1 -> RX.
- RX:
  - Shift one bit per cycle; count increments.
  - When the cycle holding bit 0 is sampled (count reaches F), the next cycle drives rx_data and rx_valid=1 for exactly 1 cycle.
  - Bits are reversed into place when LSB_FIRST=1.
  - Latency: rx_valid asserts 1 cycle after the last MOSI bit is sampled.
- Frame completion by command:
  - cmd 00/01 (write address/data): rx_valid pulse -> DONE.
  - cmd 10 (read address): rx_valid pulse, set rd_addr_seen -> DONE.
  - cmd 11 with rd_addr_seen=1: rx_valid pulse -> RD_WAIT, timeout counter 0.
  - cmd 11 with rd_addr_seen=0: no rx_valid; err_valid=1, err_code=10 -> DONE.
- RD_WAIT:
  - tx_valid=1 -> capture tx_data into shift register -> RD_SHIFT.
  - Otherwise increment the timeout counter.
  - After TX_TIMEOUT cycles without tx_valid: err_valid=1, err_code=11 -> DONE. rd_addr_seen is kept.
- RD_SHIFT:
  - miso carries payload bit DATA_W-1 first (bit 0 first if LSB_FIRST); first bit is valid the cycle after capture.
  - One bit per cycle for DATA_W cycles.
  - After the last bit: miso=0, clear rd_addr_seen -> DONE.
- DONE:
  - miso=0; all further MOSI bits ignored until ss_n=1.
- ss_n=1 in any non-IDLE state:
  - Next state IDLE; counters clear; miso=0. This has priority over tx_valid and frame completion in the same cycle.
  - If the state is CHK_CMD, RX, RD_WAIT or RD_SHIFT: err_valid=1, err_code=01, no rx_valid, rd_addr_seen unchanged.
  - If the state is DONE: no error.
- Bit counter is $clog2(F+1) bits wide; it never wraps within a frame.
- Back-to-back frames require at least one ss_n=1 cycle between them.

Decomposition:
- Package spi_slave_pkg:
  - state_e enum.
  - cmd_e: CMD_WR_ADDR=00, CMD_WR_DATA=01, CMD_RD_ADDR=10, CMD_RD_DATA=11.
  - err_e: ERR_ABORT=01, ERR_NO_ADDR=10, ERR_TIMEOUT=11.
- Sub-module spi_bit_shifter: parametrised W-bit shift register with load, shift-in, shift-out and a bit-order parameter. Instantiated once for RX and once for TX.

Test Plan:
- Write address, DATA_W=8: frame 00_1010_0101 MSB first -> rx_data=10'h0A5, rx_valid high exactly 1 cycle, 1 cycle after the 10th bit; miso stays 0.
- Read sequence: frame 10_0000_0011 -> rx_valid with 10'h203. Then frame 11_xxxx_xxxx -> rx_valid, RD_WAIT. tx_valid with tx_data=8'hC3 after 3 cycles -> miso 1,1,0,0,0,0,1,1 on the following 8 cycles; rd_addr_seen cleared.
- cmd 11 after reset with no read address -> no rx_valid; err_valid pulse, err_code=10.
- ss_n raised after 5 bits of a write frame -> IDLE next cycle, err_code=01, no rx_valid. A subsequent full frame is received correctly.
- LSB_FIRST=1: payload bits 1,0,1,0,0,1,0,1 after cmd 01 -> rx_data=10'h1A5. Read with tx_data=8'h01 -> miso first bit 1.
- RD_WAIT with tx_valid never asserted -> err_code=11 after 15 cycles. A second cmd 11 frame then succeeds without resending the address.
